// File: rtl/mct_stage_sequencer_pkg.sv
// Shared encodings for the MCT stage sequencer: instruction classes, stage
// register values and one-hot time-pulse indices.
package mct_stage_sequencer_pkg;

    localparam int T_W   = 12;
    localparam int PHS_W = 2;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        CLS_PLAIN = 2'd0,
        CLS_MP    = 2'd1,
        CLS_DV    = 2'd2
    } cls_e;

    typedef enum logic [2:0] {
        ST_0 = 3'd0,
        ST_1 = 3'd1,
        ST_3 = 3'd3,
        ST_4 = 3'd4
    } stage_e;

    localparam int T01 = 0;
    localparam int T02 = 1;
    localparam int T03 = 2;
    localparam int T04 = 3;
    localparam int T05 = 4;
    localparam int T06 = 5;
    localparam int T07 = 6;
    localparam int T08 = 7;
    localparam int T09 = 8;
    localparam int T10 = 9;
    localparam int T11 = 10;
    localparam int T12 = 11;

endpackage

// File: rtl/mct_stage_sequencer_if.sv
// Control/status bundle between the sequencer and its neighbours: restart,
// class and branch inputs in, time pulses and stage state out.
interface mct_stage_sequencer_if;
    import mct_stage_sequencer_pkg::*;

    logic             GOJAM;
    logic [1:0]       CLASS;
    logic             CLASS_VLD;
    logic             BRSGN;
    logic             BRZER;
    logic             BRLD;
    logic [T_W-1:0]   T;
    logic [PHS_W-1:0] PHS;
    logic [2:0]       ST;
    logic             BR1;
    logic             BR2;
    logic             NISQ;
    logic             BUSY;

    modport master (
        output GOJAM, CLASS, CLASS_VLD, BRSGN, BRZER, BRLD,
        input  T, PHS, ST, BR1, BR2, NISQ, BUSY
    );

    modport slave (
        input  GOJAM, CLASS, CLASS_VLD, BRSGN, BRZER, BRLD,
        output T, PHS, ST, BR1, BR2, NISQ, BUSY
    );

endinterface

// File: rtl/mct_stage_sequencer_timer.sv
// Free-running phase counter and T01..T12 one-hot ring; flags the last phase
// of each pulse and the end-of-MCT strobe.
module mct_timer
    import mct_stage_sequencer_pkg::*;
#(
    parameter int PHASES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [PHS_W-1:0] phs,
    output logic [T_W-1:0]   t,
    output logic             last_phs,
    output logic             eom
);

    localparam logic [PHS_W-1:0] PHS_MAX = PHS_W'(PHASES - 1);
    localparam logic [T_W-1:0]   T_INIT  = T_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phs <= '0;
            t   <= T_INIT;
        end else if (clr) begin
            phs <= '0;
            t   <= T_INIT;
        end else if (phs == PHS_MAX) begin
            phs <= '0;
            t   <= {t[T_W-2:0], t[T_W-1]};
        end else begin
            phs <= phs + PHS_W'(1);
        end
    end

    assign last_phs = (phs == PHS_MAX);
    assign eom      = last_phs & t[T12];

endmodule

// File: rtl/mct_stage_sequencer.sv
// Stage sequencer: walks ST through plain/MP/DV instruction stages one MCT at
// a time, holds BR1/BR2 and raises NISQ during the final MCT.
module mct_stage_sequencer
    import mct_stage_sequencer_pkg::*;
#(
    parameter int PHASES   = 4,
    parameter int MP_MCTS  = 3,
    parameter int DV_LOOPS = 4
) (
    input logic CLOCK,
    input logic rst,
    mct_stage_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] MP_LAST = CNT_W'(MP_MCTS - 3);
    localparam logic [CNT_W-1:0] DV_LAST = CNT_W'(DV_LOOPS - 1);

    logic [PHS_W-1:0] phs;
    logic [T_W-1:0]   t;
    logic             last_phs;
    logic             eom;

    stage_e           st;
    cls_e             cls;
    logic [CNT_W-1:0] cnt;
    logic             nisq;
    logic             busy;
    logic             br1;
    logic             br2;
    logic             br_pend;

    mct_timer #(
        .PHASES (PHASES)
    ) u_timer (
        .clk      (CLOCK),
        .rst      (rst),
        .clr      (bus.GOJAM),
        .phs      (phs),
        .t        (t),
        .last_phs (last_phs),
        .eom      (eom)
    );

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            st      <= ST_0;
            cls     <= CLS_PLAIN;
            cnt     <= '0;
            nisq    <= 1'b1;
            busy    <= 1'b0;
            br1     <= 1'b0;
            br2     <= 1'b0;
            br_pend <= 1'b0;
        end else if (bus.GOJAM) begin
            st      <= ST_0;
            cls     <= CLS_PLAIN;
            cnt     <= '0;
            nisq    <= 1'b1;
            busy    <= 1'b0;
            br1     <= 1'b0;
            br2     <= 1'b0;
            br_pend <= 1'b0;
        end else begin
            // A BRLD anywhere in T07 is remembered and acted on at its last phase.
            if (t[T07] && !last_phs && bus.BRLD)
                br_pend <= 1'b1;
            if (t[T07] && last_phs) begin
                if (br_pend || bus.BRLD) begin
                    br1 <= bus.BRSGN;
                    br2 <= bus.BRZER;
                end
                br_pend <= 1'b0;
            end

            if (eom) begin
                if (nisq) begin
                    st  <= ST_0;
                    cnt <= '0;
                    br1 <= 1'b0;
                    br2 <= 1'b0;
                    if (bus.CLASS_VLD && bus.CLASS == CLS_MP) begin
                        cls  <= CLS_MP;
                        nisq <= 1'b0;
                        busy <= 1'b1;
                    end else if (bus.CLASS_VLD && bus.CLASS == CLS_DV) begin
                        cls  <= CLS_DV;
                        nisq <= 1'b0;
                        busy <= 1'b1;
                    end else begin
                        cls  <= CLS_PLAIN;
                        nisq <= 1'b1;
                        busy <= 1'b0;
                    end
                end else begin
                    case (st)
                        ST_0: st <= ST_1;
                        ST_1: begin
                            // MP lingers in stage 1 until its MCT budget leaves one for stage 3.
                            if (cls == CLS_MP && cnt != MP_LAST) begin
                                cnt <= cnt + CNT_W'(1);
                            end else begin
                                st  <= ST_3;
                                cnt <= '0;
                                if (cls == CLS_MP)
                                    nisq <= 1'b1;
                            end
                        end
                        ST_3: begin
                            if (cnt == DV_LAST) begin
                                st   <= ST_4;
                                nisq <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                        default: begin
                            st   <= ST_0;
                            cls  <= CLS_PLAIN;
                            nisq <= 1'b1;
                            busy <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.T    = t;
    assign bus.PHS  = phs;
    assign bus.ST   = st;
    assign bus.BR1  = br1;
    assign bus.BR2  = br2;
    assign bus.NISQ = nisq;
    assign bus.BUSY = busy;

endmodule

// File: tb/tb_mct_stage_sequencer.sv
// Bench for mct_stage_sequencer: directed table, async-reset sequence and a
// randomized run against a cycle-count / stage-queue reference model.
module tb_mct_stage_sequencer;
    import mct_stage_sequencer_pkg::*;

    localparam int P   = 4;
    localparam int MPM = 3;
    localparam int DVL = 4;

    logic CLOCK = 1'b0;
    logic rst;

    mct_stage_sequencer_if bus();

    mct_stage_sequencer #(
        .PHASES   (P),
        .MP_MCTS  (MPM),
        .DV_LOOPS (DVL)
    ) dut (
        .CLOCK (CLOCK),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [2:0] st;
        logic       nisq;
        logic       busy;
    } mrec_t;

    typedef struct {
        int         n;
        logic       gj;
        logic [1:0] cl;
        logic       vld;
        logic       bl;
        logic       bs;
        logic       bz;
        logic [11:0] et;
        logic [1:0] ep;
        logic [2:0] es;
        logic       en;
        logic       eb;
        logic       e1;
        logic       e2;
    } vec_t;

    mrec_t q[$];
    int    c;
    logic  m_br1, m_br2, m_seen;
    int    tests = 0;
    int    fails = 0;
    vec_t  tbl[22];

    function automatic mrec_t mk(input logic [2:0] s, input logic n, input logic b);
        mrec_t r;
        r.st = s; r.nisq = n; r.busy = b;
        return r;
    endfunction

    // Each instruction becomes the list of (ST, NISQ, BUSY) it shows, one per MCT.
    function automatic void fill(input logic [1:0] cls);
        q.delete();
        if (cls == 2'd1) begin
            q.push_back(mk(3'd0, 1'b0, 1'b1));
            for (int i = 0; i < MPM - 2; i++) q.push_back(mk(3'd1, 1'b0, 1'b1));
            q.push_back(mk(3'd3, 1'b1, 1'b1));
        end else if (cls == 2'd2) begin
            q.push_back(mk(3'd0, 1'b0, 1'b1));
            q.push_back(mk(3'd1, 1'b0, 1'b1));
            for (int i = 0; i < DVL; i++) q.push_back(mk(3'd3, 1'b0, 1'b1));
            q.push_back(mk(3'd4, 1'b1, 1'b1));
        end else begin
            q.push_back(mk(3'd0, 1'b1, 1'b0));
        end
    endfunction

    function automatic void model_reset();
        c = 0; m_br1 = 1'b0; m_br2 = 1'b0; m_seen = 1'b0;
        fill(2'd0);
    endfunction

    function automatic void model_step();
        int ti, ph;
        if (bus.GOJAM) begin
            model_reset();
            return;
        end
        ti = (c / P) % 12;
        ph = c % P;
        if (ti == 6) begin
            if (bus.BRLD) m_seen = 1'b1;
            if (ph == P - 1) begin
                if (m_seen) begin m_br1 = bus.BRSGN; m_br2 = bus.BRZER; end
                m_seen = 1'b0;
            end
        end
        if (ti == 11 && ph == P - 1) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
                m_br1 = 1'b0; m_br2 = 1'b0;
                fill(bus.CLASS_VLD ? bus.CLASS : 2'd0);
            end
        end
        c++;
    endfunction

    function automatic logic [20:0] dut_vec();
        return {bus.T, bus.PHS, bus.ST, bus.NISQ, bus.BUSY, bus.BR1, bus.BR2};
    endfunction

    task automatic check_model(input string name);
        logic [20:0] want;
        logic [11:0] et;
        et = 12'd1 << ((c / P) % 12);
        want = {et, 2'(c % P), q[0].st, q[0].nisq, q[0].busy, m_br1, m_br2};
        tests++;
        if (dut_vec() !== want) begin
            fails++;
            $display("FAIL %s c=%0d got %h want %h", name, c, dut_vec(), want);
        end
    endtask

    task automatic check_exp(input string name, input logic [11:0] et, input logic [1:0] ep,
                             input logic [2:0] es, input logic en, input logic eb,
                             input logic e1, input logic e2);
        logic [20:0] want;
        want = {et, ep, es, en, eb, e1, e2};
        tests++;
        if (dut_vec() !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", name, dut_vec(), want);
        end
    endtask

    task automatic cycle(input logic gj, input logic [1:0] cl, input logic vld,
                         input logic bl, input logic bs, input logic bz);
        bus.GOJAM = gj; bus.CLASS = cl; bus.CLASS_VLD = vld;
        bus.BRLD = bl; bus.BRSGN = bs; bus.BRZER = bz;
        model_step();
        @(posedge CLOCK);
        @(negedge CLOCK);
        check_model("model");
    endtask

    initial begin
        tbl[0]  = '{20, 0, 0, 0, 0, 0, 0, 12'h020, 0, 0, 1, 0, 0, 0};
        tbl[1]  = '{27, 0, 1, 1, 0, 0, 0, 12'h800, 3, 0, 1, 0, 0, 0};
        tbl[2]  = '{1,  0, 1, 1, 0, 0, 0, 12'h001, 0, 0, 0, 1, 0, 0};
        tbl[3]  = '{48, 0, 0, 0, 0, 0, 0, 12'h001, 0, 1, 0, 1, 0, 0};
        tbl[4]  = '{48, 0, 0, 0, 0, 0, 0, 12'h001, 0, 3, 1, 1, 0, 0};
        tbl[5]  = '{17, 0, 0, 0, 1, 1, 0, 12'h010, 1, 3, 1, 1, 0, 0};
        tbl[6]  = '{8,  0, 0, 0, 0, 0, 0, 12'h040, 1, 3, 1, 1, 0, 0};
        tbl[7]  = '{1,  0, 0, 0, 1, 1, 0, 12'h040, 2, 3, 1, 1, 0, 0};
        tbl[8]  = '{2,  0, 0, 0, 0, 1, 0, 12'h080, 0, 3, 1, 1, 1, 0};
        tbl[9]  = '{20, 0, 0, 0, 0, 0, 0, 12'h001, 0, 0, 1, 0, 0, 0};
        tbl[10] = '{48, 0, 2, 1, 0, 0, 0, 12'h001, 0, 0, 0, 1, 0, 0};
        tbl[11] = '{48, 0, 1, 1, 0, 0, 0, 12'h001, 0, 1, 0, 1, 0, 0};
        tbl[12] = '{48, 0, 0, 0, 0, 0, 0, 12'h001, 0, 3, 0, 1, 0, 0};
        tbl[13] = '{48, 0, 0, 0, 0, 0, 0, 12'h001, 0, 3, 0, 1, 0, 0};
        tbl[14] = '{48, 0, 0, 0, 0, 0, 0, 12'h001, 0, 3, 0, 1, 0, 0};
        tbl[15] = '{48, 0, 0, 0, 0, 0, 0, 12'h001, 0, 3, 0, 1, 0, 0};
        tbl[16] = '{48, 0, 0, 0, 0, 0, 0, 12'h001, 0, 4, 1, 1, 0, 0};
        tbl[17] = '{48, 0, 3, 1, 0, 0, 0, 12'h001, 0, 0, 1, 0, 0, 0};
        tbl[18] = '{48, 0, 2, 1, 0, 0, 0, 12'h001, 0, 0, 0, 1, 0, 0};
        tbl[19] = '{80, 0, 0, 0, 1, 0, 1, 12'h100, 0, 1, 0, 1, 0, 1};
        tbl[20] = '{1,  1, 0, 0, 0, 0, 0, 12'h001, 0, 0, 1, 0, 0, 0};
        tbl[21] = '{5,  0, 0, 0, 0, 0, 0, 12'h002, 1, 0, 1, 0, 0, 0};

        rst = 1'b1;
        bus.GOJAM = 0; bus.CLASS = 0; bus.CLASS_VLD = 0;
        bus.BRLD = 0; bus.BRSGN = 0; bus.BRZER = 0;
        repeat (3) @(negedge CLOCK);
        check_exp("reset", 12'h001, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 22; i++) begin
            for (int k = 0; k < tbl[i].n; k++)
                cycle(tbl[i].gj, tbl[i].cl, tbl[i].vld, tbl[i].bl, tbl[i].bs, tbl[i].bz);
            check_exp($sformatf("vec%0d", i), tbl[i].et, tbl[i].ep, tbl[i].es,
                      tbl[i].en, tbl[i].eb, tbl[i].e1, tbl[i].e2);
        end

        // Asynchronous reset in the middle of an MP instruction.
        for (int k = 0; k < 43; k++) cycle(0, 2'd1, 1, 0, 0, 0);
        check_exp("mp_start", 12'h001, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 62; k++) cycle(0, 2'd0, 0, 0, 0, 0);
        check_exp("mp_t04", 12'h008, 2'd2, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 check_exp("async_rst", 12'h001, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge CLOCK);
        rst = 1'b0;
        for (int k = 0; k < 48; k++) cycle(0, 2'd0, 0, 0, 0, 0);
        check_exp("after_rst", 12'h001, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 3000; k++)
            cycle(($urandom_range(0, 299) == 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mct_stage_sequencer.md
Name: mct_stage_sequencer

Overview:
- Sequences memory-cycle-time (MCT) timing and instruction staging for the control-pulse crosspoint logic.
- Generates the T01–T12 time-pulse ring, the per-MCT phase count and the stage register ST[2:0] for single- and multi-MCT instructions (plain, MP, DV).
- Holds the branch flip-flops BR1/BR2 and requests the next instruction at the end of the final MCT.
- Sits between the timer and the stage/branch crosspoint modules; replaces their free-running stage inputs.

Parameters:
- PHASES, 4, clock cycles per time pulse (≥2)
- MP_MCTS, 3, total MCTs for class MP
- DV_LOOPS, 4, repetitions of DV stage 3 (≥1)

Ports:
- CLOCK  in  1  system clock
- rst  in  1  asynchronous active-high reset
- GOJAM  in  1  synchronous restart, highest priority after rst
- CLASS  in  2  class of the instruction being started: 0 plain, 1 MP, 2 DV, 3 treated as plain
- CLASS_VLD  in  1  CLASS valid; sampled at the last phase of T12 while NISQ=1
- BRSGN  in  1  sign of sum bit
- BRZER  in  1  zero-detect of sum
- BRLD  in  1  capture branch bits at the end of the current T07
- T  out  12  one-hot time pulse, T[0]=T01
- PHS  out  2  phase within the current T, 0..PHASES-1
- ST  out  3  stage register
- BR1  out  1  branch bit 1
- BR2  out  1  branch bit 2
- NISQ  out  1  next-instruction request
- BUSY  out  1  multi-MCT instruction in progress

Behaviour:
- Reset (async, rst=1): T=T01, PHS=0, ST=0, BR1=BR2=0, NISQ=1, BUSY=0, class register=plain, loop counter=0.
- Timing:
  - PHS increments every CLOCK and wraps at PHASES-1.
  - On the wrap, T rotates T01→T02→…→T12→T01.
  - One MCT = 12*PHASES cycles. The ring never stalls.
- End-of-MCT strobe (EOM) = T12 and PHS=PHASES-1. All stage updates happen only on EOM.
- NISQ=1 during the final MCT of an instruction.
  - On EOM with NISQ=1: latch CLASS if CLASS_VLD=1, else plain.
  - Latched plain: ST=0, NISQ stays 1, BUSY=0.
  - Latched MP: ST=0, NISQ=0, BUSY=1.
  - Latched DV: ST=0, NISQ=0, BUSY=1, loop counter=0.
- MP sequence, one stage per MCT:
  - ST: 0→1→3, with 3 final (NISQ=1) when MP_MCTS=3.
  - For MP_MCTS>3, stage 1 repeats (MP_MCTS-2) times before 3.
- DV sequence:
  - ST: 0→1→3 repeated DV_LOOPS times→4 final (NISQ=1).
  - The loop counter increments on each EOM in stage 3 and saturates at DV_LOOPS-1 before moving to stage 4.
- Leaving the final MCT: ST returns to 0 and BUSY drops on the same EOM that latches the next class.
- Branch capture:
  - If BRLD=1 during any cycle of T07, then at T07/PHS=PHASES-1: BR1←BRSGN, BR2←BRZER.
  - BRLD pulses outside T07 are ignored.
  - BR bits hold across MCTs and are cleared on the EOM that starts a new instruction.
  - BR bits are not cleared between stages of the same instruction.
- GOJAM (synchronous, on the next edge): T=T01, PHS=0, ST=0, BR=0, NISQ=1, BUSY=0, loop counter=0. Behaves the same as rst, except synchronous.
- Simultaneous events:
  - GOJAM overrides EOM and BRLD.
  - BRLD at T07 cannot coincide with EOM.
  - CLASS_VLD outside the final-MCT EOM is ignored.
- rst or GOJAM mid-instruction aborts it. No partial stage is retained.
- All outputs are registered: no combinational input→output paths.

Decomposition:
- Shared package holds:
  - class encodings: CLS_PLAIN, CLS_MP, CLS_DV
  - stage constants: ST_0, ST_1, ST_3, ST_4
  - T one-hot index constants T01..T12
- Sub-module mct_timer: PHS counter plus T ring with an EOM output, reusable elsewhere.
- Stage FSM and branch logic live in the top level.

Test Plan:
- Release rst, no CLASS_VLD → T cycles T01..T12 every 12*4=48 clocks; ST=0 and NISQ=1 throughout; BUSY=0.
- CLASS=MP valid at EOM → ST sequence 0,1,3 over three MCTs (144 clocks); NISQ=1 only in the ST=3 MCT; BUSY=1 during MCTs 1–3, then 0.
- CLASS=DV, DV_LOOPS=4 → ST 0,1,3,3,3,3,4 over seven MCTs; NISQ=1 only in ST=4.
- BRLD=1 in T07 with BRSGN=1, BRZER=0 → BR1=1, BR2=0 from the cycle after T07 end. BRLD in T05 → no change. New instruction EOM → BR=00.
- GOJAM asserted in MCT 2 of DV at T09 → next cycle T=T01, PHS=0, ST=0, BUSY=0, NISQ=1, BR=00.
- rst pulsed mid-MP at T04 PHS=2 → outputs go to reset values immediately (asynchronous); the sequence restarts cleanly after release.
